// File: rtl/busmux_arbiter_pkg.sv
// Shared definitions for the busmux arbiter family.
//   state_t    : arbiter FSM state encoding (IDLE / GRANT / LOCK)
//   MODE_*     : arbitration mode selectors for the RR_MODE parameter
//   clog2      : ceiling log2, used to size encoded source indices
package busmux_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/busmux_arbiter_prio_enc.sv
// Rotated priority encoder.
//   req   : request vector, one bit per source
//   base  : index where the search starts; the search wraps modulo NUM_SRC
//   found : at least one request is active
//   idx   : first active request at or after base (0 when none found)
// Tie base to 0 for plain lowest-index-wins priority.
module busmux_prio_enc
  import busmux_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 24,
  localparam int unsigned SEL_W   = clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   base,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  int unsigned pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pos = 32'(base) + i;
      if (pos >= NUM_SRC) pos = pos - NUM_SRC;
      if (!found && req[SEL_W'(pos)]) begin
        found = 1'b1;
        idx   = SEL_W'(pos);
      end
    end
  end

endmodule

// File: rtl/busmux_arbiter.sv
// Registered shared-bus multiplexer with arbitration.
//   clock        : rising-edge clock
//   clear        : synchronous active-high reset, overrides all other inputs
//   src_data     : NUM_SRC packed source words, source i at [i*DATA_W +: DATA_W]
//   src_req      : per-source drive request
//   hold         : keep the current owner while it still requests
//   bus_out      : registered word of the owner, 0 when idle
//   bus_valid    : bus_out carries a granted source's data
//   grant        : one-hot owner, all zero when idle
//   grant_idx    : encoded owner, 0 when idle
//   conflict     : more than one request was active in the previous cycle
//   conflict_cnt : saturating count of conflict cycles
// RR_MODE selects fixed priority (lowest index) or round-robin from ptr.
module busmux_arbiter
  import busmux_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 24,
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned RR_MODE = MODE_FIXED,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned SEL_W   = clog2(NUM_SRC)
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic                      hold,
  output logic [DATA_W-1:0]         bus_out,
  output logic                      bus_valid,
  output logic [NUM_SRC-1:0]        grant,
  output logic [SEL_W-1:0]          grant_idx,
  output logic                      conflict,
  output logic [CNT_W-1:0]          conflict_cnt
);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [SEL_W-1:0]   enc_base, enc_idx, owner_nxt;
  logic               enc_found, keep, multi, own_nxt;
  logic [NUM_SRC-1:0] grant_nxt;

  assign enc_base = (RR_MODE == MODE_RR) ? ptr : '0;

  busmux_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_enc (
    .req   (src_req),
    .base  (enc_base),
    .found (enc_found),
    .idx   (enc_idx)
  );

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi = |(src_req & (src_req - NUM_SRC'(1)));

  // Losing the lock falls straight through to arbitration in the same cycle,
  // so a release never inserts an idle bubble.
  always_comb begin
    state_nxt = ST_IDLE;
    owner_nxt = '0;
    ptr_nxt   = ptr;
    keep      = (state != ST_IDLE) && hold && src_req[grant_idx];
    if (keep) begin
      state_nxt = ST_LOCK;
      owner_nxt = grant_idx;
    end else if (enc_found) begin
      state_nxt = ST_GRANT;
      owner_nxt = enc_idx;
      if (RR_MODE == MODE_RR)
        ptr_nxt = (32'(enc_idx) == NUM_SRC - 1) ? '0 : enc_idx + SEL_W'(1);
    end
    own_nxt   = (state_nxt != ST_IDLE);
    grant_nxt = own_nxt ? (NUM_SRC'(1) << owner_nxt) : '0;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      bus_out      <= '0;
      bus_valid    <= 1'b0;
      grant        <= '0;
      grant_idx    <= '0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      bus_valid <= own_nxt;
      grant     <= grant_nxt;
      grant_idx <= owner_nxt;
      bus_out   <= own_nxt ? src_data[owner_nxt*DATA_W +: DATA_W] : '0;
      conflict  <= multi;
      if (multi && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_busmux_arbiter.sv
module tb_busmux_arbiter;
  import busmux_arbiter_pkg::*;

  localparam int unsigned N = 24;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           clear = 1'b1;
  logic           hold = 1'b0;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_req = '0;

  logic [W-1:0] bus0, bus1, bus2;
  logic         v0, v1, v2, c0, c1, c2;
  logic [N-1:0] g0, g1, g2;
  logic [4:0]   i0, i1, i2;
  logic [7:0]   n0, n1;
  logic [1:0]   n2;

  busmux_arbiter #(.NUM_SRC(N), .DATA_W(W), .RR_MODE(0), .CNT_W(8)) dut_fix (
    .clock(clk), .clear(clear), .src_data(src_data), .src_req(src_req), .hold(hold),
    .bus_out(bus0), .bus_valid(v0), .grant(g0), .grant_idx(i0),
    .conflict(c0), .conflict_cnt(n0));

  busmux_arbiter #(.NUM_SRC(N), .DATA_W(W), .RR_MODE(1), .CNT_W(8)) dut_rr (
    .clock(clk), .clear(clear), .src_data(src_data), .src_req(src_req), .hold(hold),
    .bus_out(bus1), .bus_valid(v1), .grant(g1), .grant_idx(i1),
    .conflict(c1), .conflict_cnt(n1));

  busmux_arbiter #(.NUM_SRC(N), .DATA_W(W), .RR_MODE(0), .CNT_W(2)) dut_sat (
    .clock(clk), .clear(clear), .src_data(src_data), .src_req(src_req), .hold(hold),
    .bus_out(bus2), .bus_valid(v2), .grant(g2), .grant_idx(i2),
    .conflict(c2), .conflict_cnt(n2));

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         which;
    logic [N-1:0] g;
    logic [4:0] idx;
    logic [W-1:0] bus;
    logic       v;
    logic       c;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [W-1:0] dflt(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  function automatic void push(input string tag, input int which, input logic v,
                               input int idx, input logic [W-1:0] bus,
                               input logic c, input int cnt);
    exp_t e;
    e.tag   = tag;
    e.which = which;
    e.v     = v;
    e.idx   = 5'(idx);
    e.g     = v ? (N'(1) << idx) : '0;
    e.bus   = bus;
    e.c     = c;
    e.cnt   = 8'(cnt);
    sb.push_back(e);
  endfunction

  task automatic chk(input string tag, input string f, input logic [63:0] o, input logic [63:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, o, x);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.which)
        0: begin
          chk(e.tag, "grant", 64'(g0), 64'(e.g));   chk(e.tag, "idx", 64'(i0), 64'(e.idx));
          chk(e.tag, "bus", 64'(bus0), 64'(e.bus)); chk(e.tag, "valid", 64'(v0), 64'(e.v));
          chk(e.tag, "conflict", 64'(c0), 64'(e.c)); chk(e.tag, "cnt", 64'(n0), 64'(e.cnt));
        end
        1: begin
          chk(e.tag, "grant", 64'(g1), 64'(e.g));   chk(e.tag, "idx", 64'(i1), 64'(e.idx));
          chk(e.tag, "bus", 64'(bus1), 64'(e.bus)); chk(e.tag, "valid", 64'(v1), 64'(e.v));
          chk(e.tag, "conflict", 64'(c1), 64'(e.c)); chk(e.tag, "cnt", 64'(n1), 64'(e.cnt));
        end
        default: begin
          chk(e.tag, "grant", 64'(g2), 64'(e.g));   chk(e.tag, "idx", 64'(i2), 64'(e.idx));
          chk(e.tag, "bus", 64'(bus2), 64'(e.bus)); chk(e.tag, "valid", 64'(v2), 64'(e.v));
          chk(e.tag, "conflict", 64'(c2), 64'(e.c)); chk(e.tag, "cnt", 64'(n2), 64'(e.cnt));
        end
      endcase
    end
  endtask

  task automatic push_zero_all(input string tag);
    for (int k = 0; k < 3; k++) push(tag, k, 1'b0, 0, '0, 1'b0, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    push_zero_all("clear");
    step();
    clear = 1'b0;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    src_data[i*W +: W] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr_seq[4];
    int cnt;
    rr_seq = '{0, 5, 23, 0};
    for (int i = 0; i < N; i++) set_data(i, dflt(i));

    // Reset held for two edges, then idle.
    for (int k = 0; k < 2; k++) begin
      push_zero_all("reset");
      step();
    end
    clear = 1'b0;
    push_zero_all("idle");
    step();

    // Fixed priority vs round-robin on bits 10,11.
    src_req = 24'h000C00;
    push("fp_first", 0, 1'b1, 10, dflt(10), 1'b1, 1);
    push("rr_first", 1, 1'b1, 10, dflt(10), 1'b1, 1);
    step();
    push("fp_again", 0, 1'b1, 10, dflt(10), 1'b1, 2);
    push("rr_rotate", 1, 1'b1, 11, dflt(11), 1'b1, 2);
    step();
    src_req = '0;
    push("fp_release", 0, 1'b0, 0, '0, 1'b0, 2);
    push("rr_release", 1, 1'b0, 0, '0, 1'b0, 2);
    step();
    do_clear();

    // Round-robin with wrap 23 -> 0.
    src_req = 24'h800021;
    for (int k = 0; k < 4; k++) begin
      push("rr_seq", 1, 1'b1, rr_seq[k], dflt(rr_seq[k]), 1'b1, k + 1);
      step();
    end
    src_req = '0;
    push("rr_idle", 1, 1'b0, 0, '0, 1'b0, 4);
    step();
    src_req = 24'h800021;
    push("rr_ptr_idle_frozen", 1, 1'b1, 5, dflt(5), 1'b1, 5);
    step();
    src_req = '0;
    do_clear();

    // Lock on owner 3, then release to 1 with no bubble, then clear mid-lock.
    src_req = 24'h000008;
    push("lk_g3", 0, 1'b1, 3, dflt(3), 1'b0, 0);
    push("lk_g3_rr", 1, 1'b1, 3, dflt(3), 1'b0, 0);
    step();
    src_req = 24'h00000A;
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push("lk_hold", 0, 1'b1, 3, dflt(3), 1'b1, k + 1);
      push("lk_hold_rr", 1, 1'b1, 3, dflt(3), 1'b1, k + 1);
      step();
    end
    src_req = 24'h000002;
    push("lk_drop", 0, 1'b1, 1, dflt(1), 1'b0, 3);
    push("lk_drop_rr", 1, 1'b1, 1, dflt(1), 1'b0, 3);
    step();
    push("lk_relock", 0, 1'b1, 1, dflt(1), 1'b0, 3);
    push("lk_relock_rr", 1, 1'b1, 1, dflt(1), 1'b0, 3);
    step();
    clear = 1'b1;
    push_zero_all("clr_in_lock");
    step();
    clear = 1'b0;
    hold = 1'b0;
    src_req = '0;

    // Data tracking of locked owner 17; neighbour 16 toggles.
    src_req = N'(1) << 17;
    hold = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      set_data(17, 32'(k));
      set_data(16, (k % 2 == 1) ? 32'hFFFF_FFFF : 32'h0);
      push("track", 0, 1'b1, 17, 32'(k), 1'b0, 0);
      push("track_rr", 1, 1'b1, 17, 32'(k), 1'b0, 0);
      step();
    end
    set_data(16, dflt(16));
    set_data(17, dflt(17));
    hold = 1'b0;
    src_req = '0;
    do_clear();

    // Saturating 2-bit conflict counter.
    src_req = 24'h000003;
    for (int k = 0; k < 5; k++) begin
      cnt = (k + 1 > 3) ? 3 : k + 1;
      push("sat", 2, 1'b1, 0, dflt(0), 1'b1, cnt);
      step();
    end
    src_req = '0;
    push("sat_idle", 2, 1'b0, 0, '0, 1'b0, 3);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
